// File: rtl/sr_reg_dump.sv
// sr_reg_dump: scans CPU debug registers FIRST_REG..LAST_REG and streams each one out over valid/ready.
// Define SR_REG_DUMP_CHANGE_ONLY_EN to emit only registers whose value differs from the last emitted value.
module sr_reg_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [5:0]  out_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [4:0] FIRST_IDX = FIRST_REG[4:0];
    localparam logic [4:0] LAST_IDX  = LAST_REG[4:0];

    generate
        if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : gBadRange
            $fatal(1, "sr_reg_dump: FIRST_REG <= LAST_REG <= 31 must hold");
        end
    endgenerate

    logic [1:0] state;
    logic [4:0] idx;
    logic [5:0] count;
    logic       lastIdx;
    logic       emit;

    assign lastIdx = (idx == LAST_IDX);

`ifdef SR_REG_DUMP_CHANGE_ONLY_EN
    logic [31:0] shadow [32];
    logic [31:0] seen;

    assign emit = !(seen[idx] && (shadow[idx] == regData));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                shadow[i] <= '0;
            end
        end else if (state == READ && emit) begin
            shadow[idx] <= regData;
            seen[idx]   <= 1'b1;
        end
    end
`else
    assign emit = 1'b1;
`endif

    // out_count is loaded on entry to DONE so it is already valid during the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= FIRST_IDX;
                        count <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    if (emit) begin
                        out_data  <= regData;
                        out_addr  <= idx;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end else if (lastIdx) begin
                        out_count <= count;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count     <= count + 6'd1;
                        if (lastIdx) begin
                            out_count <= count + 6'd1;
                            state     <= DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= READ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign regAddr = (state == IDLE) ? 5'd0 : idx;

endmodule
